adder_rr_scheduler: RTL and testbench



---
 rtl/adder_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_adder_rr_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin time-sharing of one external WIDTH-bit adder among NREQ requesters (optional ADDER_RR_SCHEDULER_SAT_EN saturates rsp_sum on carry).
// Latency: request accepted in cycle T returns rsp_valid in cycle T+2; one operation per 3 cycles at best.
// Backpressure: rsp_ready low holds the response and all rsp_*/add_* stable; no new request is accepted until the handshake completes.
module adder_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH:0]        add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [IDW:0]   NREQ_W = NREQ[IDW:0];
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     idx_sum;
    logic [NREQ-1:0]  grant_onehot;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum_d;

    // Search rr_ptr, rr_ptr+1, ... modulo NREQ for the first valid requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx_sum >= NREQ_W) begin
                idx_sum = idx_sum - NREQ_W;
            end
            if (!grant_vld && req_valid[idx_sum[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        op_a         = '0;
        op_b         = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_onehot[i] = 1'b1;
                op_a            = req_a[i*WIDTH +: WIDTH];
                op_b            = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (state_q == IDLE && grant_vld && !rst) ? grant_onehot : '0;

`ifdef ADDER_RR_SCHEDULER_SAT_EN
    assign sum_d = add_sum[WIDTH] ? {WIDTH{1'b1}} : add_sum[WIDTH-1:0];
`else
    assign sum_d = add_sum[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        add_a  <= op_a;
                        add_b  <= op_b;
                        rsp_id <= grant_idx;
                        rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_d;
                    rsp_carry <= add_sum[WIDTH];
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: reset, round-robin rotation, overflow, back-pressure, reset in RESP.
// Latency: n/a (bench). Backpressure: driven explicitly through rsp_ready.
// Reacts to ADDER_RR_SCHEDULER_SAT_EN for the expected overflow sum.
module tb_adder_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH:0]        add_sum;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    int n_cmp = 0;
    int n_err = 0;

    // Operand table per requester and hand-computed results.
    logic [7:0] op_a_tbl [4] = '{8'h01, 8'h10, 8'h12, 8'hF0};
    logic [7:0] op_b_tbl [4] = '{8'h02, 8'h20, 8'h34, 8'h20};
`ifdef ADDER_RR_SCHEDULER_SAT_EN
    logic [7:0] exp_sum  [4] = '{8'h03, 8'h30, 8'h46, 8'hFF};
`else
    logic [7:0] exp_sum  [4] = '{8'h03, 8'h30, 8'h46, 8'h10};
`endif
    logic       exp_cy   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    // Shared adder model.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a_tbl[i];
            req_b[i*WIDTH +: WIDTH] = op_b_tbl[i];
        end

        // Reset held two cycles with everyone valid.
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_add_a",     32'(add_a),     32'h0);
        chk("rst_add_b",     32'(add_b),     32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_rsp_sum",   32'(rsp_sum),   32'h0);
        rst = 1'b0;
        #1;

        // Round-robin with all valid: ids 0,1,2,3,0,1, one grant every 3 cycles.
        for (int n = 0; n < 6; n++) begin
            chk("rr_grant",      32'(req_ready), 32'(4'b0001 << (n % 4)));
            tick();
            chk("rr_exec_ready", 32'(req_ready), 32'h0);
            chk("rr_add_a",      32'(add_a),     32'(op_a_tbl[n % 4]));
            chk("rr_add_b",      32'(add_b),     32'(op_b_tbl[n % 4]));
            tick();
            chk("rr_rsp_valid",  32'(rsp_valid), 32'h1);
            chk("rr_rsp_id",     32'(rsp_id),    32'(n % 4));
            chk("rr_rsp_sum",    32'(rsp_sum),   32'(exp_sum[n % 4]));
            chk("rr_rsp_carry",  32'(rsp_carry), 32'(exp_cy[n % 4]));
            chk("rr_resp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("rr_rsp_done",   32'(rsp_valid), 32'h0);
        end

        // No requests: idle.
        req_valid = 4'h0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("idle_req_ready2", 32'(req_ready), 32'h0);

        // Back-pressure on requester 3 (overflow operands), then wrap to 0.
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'hF;
        tick();
        chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_id",    32'(rsp_id),    32'h3);
            chk("bp_hold_sum",   32'(rsp_sum),   32'(exp_sum[3]));
            chk("bp_hold_carry", 32'(rsp_carry), 32'h1);
            chk("bp_hold_ready", 32'(req_ready), 32'h0);
            chk("bp_hold_add_a", 32'(add_a),     32'hF0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_pre_release", 32'(rsp_valid), 32'h1);
        tick();
        chk("bp_released", 32'(rsp_valid), 32'h0);
        chk("bp_wrap_grant", 32'(req_ready), 32'h1);

        // Single request from requester 2 while pointer sits at 0.
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("single_grant", 32'(req_ready), 32'h4);
        tick();
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id",    32'(rsp_id),    32'h2);
        chk("single_rsp_sum",   32'(rsp_sum),   32'h46);
        chk("single_rsp_carry", 32'(rsp_carry), 32'h0);
        tick();
        chk("single_hold", 32'(rsp_valid), 32'h1);

        // Reset while the response is pending: it must be dropped and rr_ptr cleared.
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rstresp_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rstresp_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("rstresp_grant0", 32'(req_ready), 32'h1);
        tick();
        tick();
        chk("post_rst_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_id",    32'(rsp_id),    32'h0);
        chk("post_rst_sum",   32'(rsp_sum),   32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
